regbank_ctrl: RTL



---
 rtl/regbank_ctrl_pkg.sv | 27 ++
 rtl/regbank_ctrl_if.sv | 29 ++
 rtl/regbank_ctrl_alu.sv | 53 +++++
 rtl/regbank_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/regbank_ctrl_pkg.sv
// Shared types and defaults for the register-bank sequencer.
// Optional build macro used by this slice: REGBANK_CTRL_SAT_EN (saturating ADD/SUB).
package regbank_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned OP_W       = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_MOV = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/regbank_ctrl_if.sv
// Instruction channel (valid/ready) between the instruction source and the sequencer.
interface regbank_ctrl_if
  import regbank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              instr_valid;
  logic              instr_ready;
  logic [OP_W-1:0]   instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs0;
  logic [ADDR_W-1:0] instr_rs1;
  logic [DATA_W-1:0] instr_imm;

  // Instruction source side
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs0, instr_rs1, instr_imm,
    input  instr_ready
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs0, instr_rs1, instr_imm,
    output instr_ready
  );

endinterface

// File: rtl/regbank_ctrl_alu.sv
// Combinational 8-bit ALU for the sequencer.
// REGBANK_CTRL_SAT_EN: when defined, ADD clamps to all ones on carry and SUB clamps
// to zero on borrow; carry still reports the raw carry/borrow.
module regbank_ctrl_alu
  import regbank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; the extra MSB of sum/diff is carry/borrow
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        carry  = sum[DATA_W];
        result = sum[DATA_W-1:0];
`ifdef REGBANK_CTRL_SAT_EN
        if (carry) result = '1;
`endif
      end
      OP_SUB: begin
        carry  = diff[DATA_W];
        result = diff[DATA_W-1:0];
`ifdef REGBANK_CTRL_SAT_EN
        if (carry) result = '0;
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LDI:  result = imm;
      OP_MOV:  result = a;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/regbank_ctrl.sv
// Initiator-side sequencer for the 4-entry register bank: accepts one instruction,
// reads operands, executes, writes back. One instruction every 4 cycles.
// Build macro REGBANK_CTRL_SAT_EN selects saturating ADD/SUB inside regbank_ctrl_alu.
module regbank_ctrl
  import regbank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  regbank_ctrl_if.slave     instr,
  output logic [ADDR_W-1:0] add_rd0,
  output logic [ADDR_W-1:0] add_rd1,
  input  logic [DATA_W-1:0] rd0,
  input  logic [DATA_W-1:0] rd1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] add_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              flag_c,
  output logic              flag_z
);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0] add_rd0_d, add_rd1_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic              wr_en_d, done_d;
  logic [ADDR_W-1:0] add_wr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic              flag_c_d, flag_z_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign instr.instr_ready = ready_q;

  regbank_ctrl_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // State register plus all registered outputs and datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      imm_q   <= '0;
      add_rd0 <= '0;
      add_rd1 <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      wr_en   <= 1'b0;
      add_wr  <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      add_rd0 <= add_rd0_d;
      add_rd1 <= add_rd1_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      wr_en   <= wr_en_d;
      add_wr  <= add_wr_d;
      wr_data <= wr_data_d;
      done    <= done_d;
      flag_c  <= flag_c_d;
      flag_z  <= flag_z_d;
    end
  end

  // Next-state and next-output logic; write-port values are prepared in EXEC
  // so that they are registered and stable for the whole WRITE cycle
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    add_rd0_d = add_rd0;
    add_rd1_d = add_rd1;
    opa_d     = opa_q;
    opb_d     = opb_q;
    wr_en_d   = 1'b0;
    add_wr_d  = '0;
    wr_data_d = '0;
    done_d    = 1'b0;
    flag_c_d  = flag_c;
    flag_z_d  = flag_z;

    case (state_q)
      IDLE: begin
        if (instr.instr_valid && ready_q) begin
          op_d      = op_e'(instr.instr_op);
          rd_d      = instr.instr_rd;
          imm_d     = instr.instr_imm;
          add_rd0_d = instr.instr_rs0;
          add_rd1_d = instr.instr_rs1;
          state_d   = READ;
        end
      end
      READ: begin
        opa_d   = rd0;
        opb_d   = rd1;
        state_d = EXEC;
      end
      EXEC: begin
        done_d = 1'b1;
        if (op_q != OP_NOP) begin
          wr_en_d   = 1'b1;
          add_wr_d  = rd_q;
          wr_data_d = alu_result;
          flag_z_d  = alu_zero;
        end
        if (op_q == OP_ADD || op_q == OP_SUB) flag_c_d = alu_carry;
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

endmodule
